// File: rtl/fft_stage2_if.sv
// Stream bundle between FFT stage 1, stage 2 and stage 3: two complex lanes in, two complex lanes out.
// in_valid-only stream with no backpressure; out_valid qualifies the output lanes, and out_first marks pair 0 of a frame.
interface fft_stage2_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_up_re;
  logic signed [WIDTH-1:0] in_up_im;
  logic signed [WIDTH-1:0] in_l_re;
  logic signed [WIDTH-1:0] in_l_im;
  logic                    out_valid;
  logic                    out_first;
  logic signed [WIDTH-1:0] out_up_re;
  logic signed [WIDTH-1:0] out_up_im;
  logic signed [WIDTH-1:0] out_l_re;
  logic signed [WIDTH-1:0] out_l_im;
  logic                    drain_state;

  modport master (
    output in_valid, in_up_re, in_up_im, in_l_re, in_l_im,
    input  out_valid, out_first, out_up_re, out_up_im, out_l_re, out_l_im, drain_state
  );

  modport slave (
    input  in_valid, in_up_re, in_up_im, in_l_re, in_l_im,
    output out_valid, out_first, out_up_re, out_up_im, out_l_re, out_l_im, drain_state
  );
endinterface

// File: rtl/fft_stage2.sv
// Stage 2 of the 32-point MDC FFT: pairs items 8 apart per lane, applies a butterfly and a W16^n twiddle,
// and emits the lane-A pairs followed by the lane-B pairs.
module fft_stage2 #(
  parameter int WIDTH = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  fft_stage2_if.slave  io
);
  localparam int PW = 2 * WIDTH + 3;
  localparam logic [0:0] DR_IDLE = 1'b0;
  localparam logic [0:0] DR_RUN  = 1'b1;

  logic [3:0] in_cnt;
  logic [2:0] dr_cnt;
  logic [0:0] dr_state;

  logic signed [WIDTH-1:0] a_re [8];
  logic signed [WIDTH-1:0] a_im [8];
  logic signed [WIDTH-1:0] bl_re [8];
  logic signed [WIDTH-1:0] bl_im [8];
  logic signed [WIDTH-1:0] bh_re [8];
  logic signed [WIDTH-1:0] bh_im [8];

  logic                    out_valid_q, out_first_q;
  logic signed [WIDTH-1:0] out_up_re_q, out_up_im_q, out_l_re_q, out_l_im_q;

  logic                    a_fire, b_fire;
  logic signed [WIDTH-1:0] x_re, x_im, y_re, y_im;
  logic [2:0]              tw_idx;
  logic signed [8:0]       w_re, w_im;
  logic signed [WIDTH:0]   s_re, s_im, d_re, d_im;
  logic signed [PW-1:0]    p_re, p_im;
  logic                    unused_bits;

  // The A half goes out as soon as its second item arrives; the B drain starts only once item 15 is in.
  assign a_fire = io.in_valid && in_cnt[3];
  assign b_fire = (dr_state == DR_RUN);

  always_comb begin
    x_re   = bl_re[dr_cnt];
    x_im   = bl_im[dr_cnt];
    y_re   = bh_re[dr_cnt];
    y_im   = bh_im[dr_cnt];
    tw_idx = dr_cnt;
    if (a_fire) begin
      x_re   = a_re[in_cnt[2:0]];
      x_im   = a_im[in_cnt[2:0]];
      y_re   = io.in_up_re;
      y_im   = io.in_up_im;
      tw_idx = in_cnt[2:0];
    end
  end

  // W16^n in Q1.7
  always_comb begin
    w_re = 9'sd128;
    w_im = 9'sd0;
    case (tw_idx)
      3'd0: begin w_re =  9'sd128; w_im =  9'sd0;   end
      3'd1: begin w_re =  9'sd118; w_im = -9'sd49;  end
      3'd2: begin w_re =  9'sd91;  w_im = -9'sd91;  end
      3'd3: begin w_re =  9'sd49;  w_im = -9'sd118; end
      3'd4: begin w_re =  9'sd0;   w_im = -9'sd128; end
      3'd5: begin w_re = -9'sd49;  w_im = -9'sd118; end
      3'd6: begin w_re = -9'sd91;  w_im = -9'sd91;  end
      3'd7: begin w_re = -9'sd118; w_im = -9'sd49;  end
      default: begin w_re = 9'sd128; w_im = 9'sd0; end
    endcase
  end

  assign s_re = (WIDTH+1)'(x_re) + (WIDTH+1)'(y_re);
  assign s_im = (WIDTH+1)'(x_im) + (WIDTH+1)'(y_im);
  assign d_re = (WIDTH+1)'(x_re) - (WIDTH+1)'(y_re);
  assign d_im = (WIDTH+1)'(x_im) - (WIDTH+1)'(y_im);

  assign p_re = PW'(d_re) * PW'(w_re) - PW'(d_im) * PW'(w_im);
  assign p_im = PW'(d_re) * PW'(w_im) + PW'(d_im) * PW'(w_re);

  assign unused_bits = ^{s_re[WIDTH], s_im[WIDTH], p_re[6:0], p_im[6:0],
                         p_re[PW-1:WIDTH+7], p_im[PW-1:WIDTH+7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt      <= '0;
      dr_cnt      <= '0;
      dr_state    <= DR_IDLE;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_up_re_q <= '0;
      out_up_im_q <= '0;
      out_l_re_q  <= '0;
      out_l_im_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        a_re[i]  <= '0;
        a_im[i]  <= '0;
        bl_re[i] <= '0;
        bl_im[i] <= '0;
        bh_re[i] <= '0;
        bh_im[i] <= '0;
      end
    end else begin
      // A drop of in_valid mid-frame returns the counter to 0, aborting the frame.
      if (io.in_valid) in_cnt <= in_cnt + 4'd1;
      else             in_cnt <= '0;

      if (io.in_valid) begin
        if (!in_cnt[3]) begin
          a_re[in_cnt[2:0]]  <= io.in_up_re;
          a_im[in_cnt[2:0]]  <= io.in_up_im;
          bl_re[in_cnt[2:0]] <= io.in_l_re;
          bl_im[in_cnt[2:0]] <= io.in_l_im;
        end else begin
          bh_re[in_cnt[2:0]] <= io.in_l_re;
          bh_im[in_cnt[2:0]] <= io.in_l_im;
        end
      end

      if (dr_state == DR_RUN) begin
        dr_cnt <= dr_cnt + 3'd1;
        if (dr_cnt == 3'd7) dr_state <= DR_IDLE;
      end
      if (io.in_valid && in_cnt == 4'd15) begin
        dr_state <= DR_RUN;
        dr_cnt   <= '0;
      end

      out_valid_q <= a_fire || b_fire;
      out_first_q <= a_fire && (in_cnt[2:0] == 3'd0);
      if (a_fire || b_fire) begin
        out_up_re_q <= s_re[WIDTH-1:0];
        out_up_im_q <= s_im[WIDTH-1:0];
        out_l_re_q  <= p_re[WIDTH+6:7];
        out_l_im_q  <= p_im[WIDTH+6:7];
      end
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_first   = out_first_q;
  assign io.out_up_re   = out_up_re_q;
  assign io.out_up_im   = out_up_im_q;
  assign io.out_l_re    = out_l_re_q;
  assign io.out_l_im    = out_l_im_q;
  assign io.drain_state = dr_state;
endmodule

// File: tb/tb_fft_stage2.sv
// Bench for fft_stage2: directed and random frames checked cycle-by-cycle against an arithmetic model.
module tb_fft_stage2;
  localparam int W  = 9;
  localparam int EW = 4 * W + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  fft_stage2_if #(.WIDTH(W)) bus ();

  fft_stage2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int tw_re [8] = '{128, 118, 91, 49, 0, -49, -91, -118};
  int tw_im [8] = '{0, -49, -91, -118, -128, -118, -91, -49};

  int fa_re [16];
  int fa_im [16];
  int fb_re [16];
  int fb_im [16];

  logic [EW-1:0] exp_q [$];
  int            exp_cyc_q [$];

  function automatic logic [W-1:0] wrapw(input int v);
    return v[W-1:0];
  endfunction

  function automatic int floor_div128(input int v);
    if (v >= 0) return v / 128;
    return -((-v + 127) / 128);
  endfunction

  function automatic logic [EW-1:0] model_pair(input int xr, input int xi, input int yr,
                                               input int yi, input int n, input bit first);
    int dr, di, pr, pi;
    dr = xr - yr;
    di = xi - yi;
    pr = dr * tw_re[n] - di * tw_im[n];
    pi = dr * tw_im[n] + di * tw_re[n];
    return {first, wrapw(xr + yr), wrapw(xi + yi), wrapw(floor_div128(pr)), wrapw(floor_div128(pi))};
  endfunction

  task automatic push_frame(input int p0);
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(model_pair(fa_re[n], fa_im[n], fa_re[n+8], fa_im[n+8], n, n == 0));
      exp_cyc_q.push_back(p0 + 8 + n);
    end
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(model_pair(fb_re[n], fb_im[n], fb_re[n+8], fb_im[n+8], n, 1'b0));
      exp_cyc_q.push_back(p0 + 16 + n);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic          exp_v;
  logic [EW-1:0] got;
  logic [EW-1:0] want;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      checks++;
      assert (bus.out_valid === exp_v) else begin
        failures++;
        $error("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        want = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        got = {bus.out_first, bus.out_up_re, bus.out_up_im, bus.out_l_re, bus.out_l_im};
        checks++;
        assert (got === want) else begin
          failures++;
          $error("FAIL pair cyc=%0d got first=%b up=(%0d,%0d) l=(%0d,%0d) exp first=%b up=(%0d,%0d) l=(%0d,%0d)",
                 cyc, got[EW-1], $signed(got[4*W-1:3*W]), $signed(got[3*W-1:2*W]),
                 $signed(got[2*W-1:W]), $signed(got[W-1:0]),
                 want[EW-1], $signed(want[4*W-1:3*W]), $signed(want[3*W-1:2*W]),
                 $signed(want[2*W-1:W]), $signed(want[W-1:0]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_frame();
    for (int k = 0; k < 16; k++) begin
      fa_re[k] = 0; fa_im[k] = 0; fb_re[k] = 0; fb_im[k] = 0;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) begin
      fa_re[k] = int'($urandom_range(0, 511)) - 256;
      fa_im[k] = int'($urandom_range(0, 511)) - 256;
      fb_re[k] = int'($urandom_range(0, 511)) - 256;
      fb_im[k] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  task automatic drive_frame(input int nitems, input bit expect_out);
    for (int k = 0; k < nitems; k++) begin
      @(negedge clk);
      if (k == 0 && expect_out) push_frame(cyc + 1);
      bus.in_valid = 1'b1;
      bus.in_up_re = fa_re[k][W-1:0];
      bus.in_up_im = fa_im[k][W-1:0];
      bus.in_l_re  = fb_re[k][W-1:0];
      bus.in_l_im  = fb_im[k][W-1:0];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    assert ({bus.out_valid, bus.out_first, bus.out_up_re, bus.out_up_im, bus.out_l_re, bus.out_l_im} === '0)
    else begin
      failures++;
      $error("FAIL %s got valid=%b first=%b up=(%0d,%0d) l=(%0d,%0d) exp all 0", tag, bus.out_valid,
             bus.out_first, bus.out_up_re, bus.out_up_im, bus.out_l_re, bus.out_l_im);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_up_re = '0;
    bus.in_up_im = '0;
    bus.in_l_re  = '0;
    bus.in_l_im  = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    idle(2);

    // Ramp on lane A
    clear_frame();
    for (int k = 0; k < 16; k++) fa_re[k] = k;
    drive_frame(16, 1'b1);
    idle(30);

    // Single nonzero lane-B item
    clear_frame();
    fb_re[8] = 50;
    drive_frame(16, 1'b1);
    idle(30);

    // Back-to-back random frames
    fill_random();
    drive_frame(16, 1'b1);
    fill_random();
    drive_frame(16, 1'b1);
    idle(30);

    // Wrap-around of the butterfly sum
    clear_frame();
    fa_re[0] = 255; fa_im[0] = -256;
    fa_re[8] = 255; fa_im[8] = -256;
    drive_frame(16, 1'b1);
    idle(30);

    // Abort: short frame, then a full one
    fill_random();
    drive_frame(5, 1'b0);
    idle(1);
    fill_random();
    drive_frame(16, 1'b1);
    idle(30);

    // Abort immediately after a full frame, while its lane-B drain is running
    fill_random();
    drive_frame(16, 1'b1);
    fill_random();
    drive_frame(5, 1'b0);
    idle(2);
    fill_random();
    drive_frame(16, 1'b1);
    idle(30);

    // Random frames with random gaps
    for (int f = 0; f < 6; f++) begin
      fill_random();
      drive_frame(16, 1'b1);
      idle(int'($urandom_range(0, 12)));
    end
    idle(30);

    // Asynchronous reset in the middle of a frame with outputs in flight
    fill_random();
    drive_frame(12, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(25);

    // Fresh frame after reset
    fill_random();
    drive_frame(16, 1'b1);
    idle(30);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_complete got pending=%0d exp 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
